// File: rtl/riscV_unrn_pkg.sv
// Shared core definitions: CLINT address-map offsets, bus request/response
// types and the decoded access kind used by the machine-timer unit.
package riscV_unrn_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;
    localparam logic [15:0] CLINT_PRESC_OFS    = 16'hC000;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } clint_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } clint_rsp_t;

    typedef enum logic [2:0] {
        ACC_ERR,
        ACC_MSIP,
        ACC_CMP_LO,
        ACC_CMP_HI,
        ACC_MTIME_LO,
        ACC_MTIME_HI,
        ACC_PRESC
    } clint_acc_e;

endpackage

// File: rtl/mtimer_clint_cmp_channel.sv
// One hart's compare channel: mtimecmp, update guard, msip bit, registered
// mtip and the high-word snapshot for tear-free mtimecmp reads.
module mtimer_cmp_channel (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_i,
    input  logic        rd_lo_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic        wr_msip_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] mtime_i,
    output logic [31:0] cmp_lo_o,
    output logic [31:0] cmp_hi_rd_o,
    output logic        msip_o,
    output logic        mtip_o
);

    logic [63:0] cmp_q;
    logic [31:0] snap_q;
    logic        lo_rd_q;
    logic        guard_q;
    logic        msip_q;
    logic        mtip_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q   <= '1;
            snap_q  <= '0;
            lo_rd_q <= 1'b0;
            guard_q <= 1'b0;
            msip_q  <= 1'b0;
            mtip_q  <= 1'b0;
        end else begin
            if (wr_lo_i) begin
                cmp_q[31:0] <= wdata_i;
                guard_q     <= 1'b1;
            end
            if (wr_hi_i) begin
                cmp_q[63:32] <= wdata_i;
                guard_q      <= 1'b0;
            end
            if (wr_msip_i) msip_q <= wdata_i[0];
            mtip_q <= (mtime_i >= cmp_q) && !guard_q;
            // Snapshot stays armed only until the next accepted request of any kind.
            if (acc_i) begin
                lo_rd_q <= rd_lo_i;
                if (rd_lo_i) snap_q <= cmp_q[63:32];
            end
        end
    end

    assign cmp_lo_o    = cmp_q[31:0];
    assign cmp_hi_rd_o = lo_rd_q ? snap_q : cmp_q[63:32];
    assign msip_o      = msip_q;
    assign mtip_o      = mtip_q;

endmodule

// File: rtl/mtimer_clint.sv
// CLINT-style machine timer: prescaled 64-bit mtime, per-hart compare and
// software-interrupt channels, single-cycle bus with registered responses.
module mtimer_clint
    import riscV_unrn_pkg::*;
#(
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 req_ready_o,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [63:0]          mtime_o
);

    localparam logic [3:0] NH = 4'(NUM_HARTS);

    clint_req_t       req;
    clint_rsp_t       rsp_d, rsp_q;
    clint_acc_e       kind;
    logic [2:0]       idx;
    logic [15:0]      off;
    logic             accept;

    logic [63:0]        mtime_q;
    logic [31:0]        snap_hi_q;
    logic               mt_lo_rd_q;
    logic [PRESC_W-1:0] presc_q, pc_q;
    logic               tick;

    logic [NUM_HARTS-1:0] ch_rd_lo, ch_wr_lo, ch_wr_hi, ch_wr_msip;
    logic [31:0]          ch_cmp_lo    [NUM_HARTS];
    logic [31:0]          ch_cmp_hi_rd [NUM_HARTS];

    assign req         = '{valid: req_valid_i, we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
    assign req_ready_o = !rst;
    assign accept      = req.valid && req_ready_o;
    assign off         = req.addr[15:0];
    assign tick        = (pc_q == presc_q);

    // BASE_ADDR is 64 KiB aligned, so the range check is an upper-half compare.
    always_comb begin
        kind = ACC_ERR;
        idx  = 3'd0;
        if (req.addr[31:16] == BASE_ADDR[31:16] && off[1:0] == 2'b00) begin
            if (off[15:5] == CLINT_MSIP_OFS[15:5]) begin
                idx = off[4:2];
                if ({1'b0, idx} < NH) kind = ACC_MSIP;
            end else if (off[15:6] == CLINT_MTIMECMP_OFS[15:6]) begin
                idx = off[5:3];
                if ({1'b0, idx} < NH) kind = off[2] ? ACC_CMP_HI : ACC_CMP_LO;
            end else if (off[15:3] == CLINT_MTIME_OFS[15:3]) begin
                kind = off[2] ? ACC_MTIME_HI : ACC_MTIME_LO;
            end else if (off == CLINT_PRESC_OFS) begin
                kind = ACC_PRESC;
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            ch_rd_lo[h]   = accept && !req.we && kind == ACC_CMP_LO && idx == 3'(h);
            ch_wr_lo[h]   = accept &&  req.we && kind == ACC_CMP_LO && idx == 3'(h);
            ch_wr_hi[h]   = accept &&  req.we && kind == ACC_CMP_HI && idx == 3'(h);
            ch_wr_msip[h] = accept &&  req.we && kind == ACC_MSIP   && idx == 3'(h);
        end
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_ch
        mtimer_cmp_channel u_ch (
            .clk         (clk),
            .rst         (rst),
            .acc_i       (accept),
            .rd_lo_i     (ch_rd_lo[g]),
            .wr_lo_i     (ch_wr_lo[g]),
            .wr_hi_i     (ch_wr_hi[g]),
            .wr_msip_i   (ch_wr_msip[g]),
            .wdata_i     (req.wdata),
            .mtime_i     (mtime_q),
            .cmp_lo_o    (ch_cmp_lo[g]),
            .cmp_hi_rd_o (ch_cmp_hi_rd[g]),
            .msip_o      (msip_o[g]),
            .mtip_o      (mtip_o[g])
        );
    end

    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = accept;
        if (accept && kind == ACC_ERR) begin
            rsp_d.err = 1'b1;
        end else if (accept && !req.we) begin
            case (kind)
                ACC_MSIP: begin
                    for (int h = 0; h < NUM_HARTS; h++)
                        if (idx == 3'(h)) rsp_d.rdata = {31'd0, msip_o[h]};
                end
                ACC_CMP_LO: begin
                    for (int h = 0; h < NUM_HARTS; h++)
                        if (idx == 3'(h)) rsp_d.rdata = ch_cmp_lo[h];
                end
                ACC_CMP_HI: begin
                    for (int h = 0; h < NUM_HARTS; h++)
                        if (idx == 3'(h)) rsp_d.rdata = ch_cmp_hi_rd[h];
                end
                ACC_MTIME_LO: rsp_d.rdata = mtime_q[31:0];
                ACC_MTIME_HI: rsp_d.rdata = mt_lo_rd_q ? snap_hi_q : mtime_q[63:32];
                ACC_PRESC:    rsp_d.rdata = 32'(presc_q);
                default:      rsp_d.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            snap_hi_q  <= '0;
            mt_lo_rd_q <= 1'b0;
            presc_q    <= '0;
            pc_q       <= '0;
            rsp_q      <= '0;
        end else begin
            if (accept && req.we && kind == ACC_PRESC) begin
                presc_q <= req.wdata[PRESC_W-1:0];
                pc_q    <= '0;
            end else begin
                pc_q <= tick ? '0 : pc_q + PRESC_W'(1);
            end
            // A bus write to either half wins over the tick for that cycle.
            if (accept && req.we && kind == ACC_MTIME_LO)      mtime_q[31:0]  <= req.wdata;
            else if (accept && req.we && kind == ACC_MTIME_HI) mtime_q[63:32] <= req.wdata;
            else if (tick)                                     mtime_q        <= mtime_q + 64'd1;
            if (accept) begin
                mt_lo_rd_q <= !req.we && kind == ACC_MTIME_LO;
                if (!req.we && kind == ACC_MTIME_LO) snap_hi_q <= mtime_q[63:32];
            end
            rsp_q <= rsp_d;
        end
    end

    assign rsp_valid_o = rsp_q.valid;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// Directed bench for mtimer_clint with two harts: a driver queues expected
// responses, a negedge monitor pops and compares them against the bus output.
module tb_mtimer_clint;

    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam logic [31:0] MSIP0   = BASE + 32'h0000;
    localparam logic [31:0] MSIP1   = BASE + 32'h0004;
    localparam logic [31:0] CMP0_LO = BASE + 32'h4000;
    localparam logic [31:0] CMP0_HI = BASE + 32'h4004;
    localparam logic [31:0] CMP1_LO = BASE + 32'h4008;
    localparam logic [31:0] CMP1_HI = BASE + 32'h400C;
    localparam logic [31:0] MT_LO   = BASE + 32'hBFF8;
    localparam logic [31:0] MT_HI   = BASE + 32'hBFFC;
    localparam logic [31:0] PRESC   = BASE + 32'hC000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  mtip_o;
    logic [1:0]  msip_o;
    logic [63:0] mtime_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    mtimer_clint #(.NUM_HARTS(2), .BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .mtip_o      (mtip_o),
        .msip_o      (msip_o),
        .mtime_o     (mtime_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input bit chk_d,
                       input string nm);
        exp_t e;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        e.rdata = exp_rd;
        e.err = exp_err;
        e.chk_data = chk_d;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp actual_rdata=%0h actual_err=%0b required=no_response",
                             rsp_rdata_o, rsp_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_err_o !== e.err || (e.chk_data && rsp_rdata_o !== e.rdata)) begin
                        failures++;
                        $display("FAIL %s actual_rdata=%0h actual_err=%0b required_rdata=%0h required_err=%0b",
                                 e.name, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [63:0] m0, m1, d;
        bit found;

        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready_o}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        chk("rst_mtip", {62'd0, mtip_o}, 64'd0);
        chk("rst_msip", {62'd0, msip_o}, 64'd0);
        rst = 1'b0;

        bus(0, CMP0_LO, 0, 32'hFFFF_FFFF, 0, 1, "cmp0_lo_reset");
        bus(0, CMP0_HI, 0, 32'hFFFF_FFFF, 0, 1, "cmp0_hi_reset");
        bus(0, MT_LO,   0, 32'h0,         0, 0, "mtime_lo_small");
        bus(0, MT_HI,   0, 32'h0,         0, 1, "mtime_hi_reset");
        idle();
        checks++;
        if (mtime_o >= 64'd16) begin
            failures++;
            $display("FAIL mtime_small actual=%0h required=below_10", mtime_o);
        end

        // Prescaler 3: one tick every 4 cycles.
        bus(1, PRESC, 32'd3, 32'd0, 0, 1, "presc_wr3");
        idle();
        m0 = mtime_o;
        repeat (40) @(negedge clk);
        d = mtime_o - m0;
        checks++;
        if (d < 64'd9 || d > 64'd11) begin
            failures++;
            $display("FAIL presc3_advance actual=%0d required=10+-1", d);
        end
        bus(0, PRESC, 0, 32'd3, 0, 1, "presc_rd3");
        bus(1, PRESC, 32'd0, 32'd0, 0, 1, "presc_wr0");
        idle();
        m0 = mtime_o;
        repeat (5) @(negedge clk);
        m1 = mtime_o;
        chk("presc0_advance", m1 - m0, 64'd5);

        // Low word about to carry into the high word.
        bus(1, MT_HI, 32'h0,         32'h0, 0, 1, "mt_wr_hi");
        bus(1, MT_LO, 32'hFFFF_FFFF, 32'h0, 0, 1, "mt_wr_lo");
        bus(0, MT_LO, 0, 32'hFFFF_FFFF, 0, 1, "mt_rd_lo_carry");
        bus(0, MT_HI, 0, 32'h0,         0, 1, "mt_rd_hi_snap");
        bus(0, MT_HI, 0, 32'h1,         0, 1, "mt_rd_hi_live");
        bus(0, MT_LO, 0, 32'h2,         0, 1, "mt_rd_lo_after");

        // Hart 1 compare at 100 with mtime restarted from 0.
        bus(1, MT_HI,   32'h0,  32'h0, 0, 1, "mt_wr_hi0");
        bus(1, MT_LO,   32'h0,  32'h0, 0, 1, "mt_wr_lo0");
        bus(1, CMP1_HI, 32'h0,  32'h0, 0, 1, "cmp1_wr_hi_a");
        bus(1, CMP1_LO, 32'd100, 32'h0, 0, 1, "cmp1_wr_lo");
        bus(1, CMP1_HI, 32'h0,  32'h0, 0, 1, "cmp1_wr_hi_b");
        idle();
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (mtime_o == 64'd100) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("mtime_reach_100", {63'd0, found}, 64'd1);
        chk("mtip1_at_100", {63'd0, mtip_o[1]}, 64'd0);
        @(negedge clk);
        chk("mtip1_after_100", {63'd0, mtip_o[1]}, 64'd1);
        chk("mtip0_quiet", {63'd0, mtip_o[0]}, 64'd0);
        bus(0, CMP1_LO, 0, 32'd100, 0, 1, "cmp1_rd_lo");
        bus(0, CMP1_HI, 0, 32'd0,   0, 1, "cmp1_rd_hi");

        // Guard forces mtip low while mtimecmp is half-updated.
        bus(1, CMP1_LO, 32'd100, 32'h0, 0, 1, "cmp1_guard_lo");
        idle();
        chk("mtip1_before_guard", {63'd0, mtip_o[1]}, 64'd1);
        @(negedge clk);
        chk("mtip1_guarded", {63'd0, mtip_o[1]}, 64'd0);
        bus(1, CMP1_HI, 32'h0, 32'h0, 0, 1, "cmp1_unguard_hi");
        idle();
        chk("mtip1_unguard_lag", {63'd0, mtip_o[1]}, 64'd0);
        @(negedge clk);
        chk("mtip1_unguarded", {63'd0, mtip_o[1]}, 64'd1);

        bus(1, MSIP1, 32'hFFFF_FFFF, 32'h0, 0, 1, "msip1_wr1");
        idle();
        chk("msip_set", {62'd0, msip_o}, 64'h2);
        bus(0, MSIP1, 0, 32'd1, 0, 1, "msip1_rd1");
        bus(0, MSIP0, 0, 32'd0, 0, 1, "msip0_rd0");
        bus(1, MSIP1, 32'h0, 32'h0, 0, 1, "msip1_wr0");
        idle();
        chk("msip_clear", {62'd0, msip_o}, 64'h0);
        bus(0, MSIP1, 0, 32'd0, 0, 1, "msip1_rd0");

        idle();
        m0 = mtime_o;
        bus(0, BASE + 32'h4010,  0,      32'h0, 1, 1, "err_cmp2_rd");
        bus(1, BASE + 32'h4010,  32'd5,  32'h0, 1, 1, "err_cmp2_wr");
        bus(0, BASE + 32'h10002, 0,      32'h0, 1, 1, "err_outside_rd");
        bus(1, BASE + 32'h10004, 32'd1,  32'h0, 1, 1, "err_outside_wr");
        bus(1, BASE + 32'hBFF9,  32'd0,  32'h0, 1, 1, "err_misalign_wr");
        bus(0, BASE + 32'h8000,  0,      32'h0, 1, 1, "err_unmapped_rd");
        bus(1, BASE + 32'h0008,  32'd1,  32'h0, 1, 1, "err_msip2_wr");
        bus(0, CMP0_LO, 0, 32'hFFFF_FFFF, 0, 1, "cmp0_lo_unchanged");
        bus(0, CMP1_LO, 0, 32'd100,       0, 1, "cmp1_lo_unchanged");
        idle();
        chk("err_msip_unchanged", {62'd0, msip_o}, 64'h0);
        checks++;
        if (mtime_o <= m0) begin
            failures++;
            $display("FAIL err_mtime_unchanged actual=%0h required_above=%0h", mtime_o, m0);
        end

        // Reset raised in the same cycle as a read: no response follows.
        repeat (2) @(negedge clk);
        rst         = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = MT_LO;
        @(negedge clk);
        chk("rst_drop_rsp", {63'd0, rsp_valid_o}, 64'd0);
        chk("rst_drop_ready", {63'd0, req_ready_o}, 64'd0);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_mtime", mtime_o, 64'd0);
        chk("rst2_mtip", {62'd0, mtip_o}, 64'd0);
        bus(0, CMP1_LO, 0, 32'hFFFF_FFFF, 0, 1, "cmp1_lo_after_rst");
        idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
